// File: rtl/fcp_volt_ramp_ctrl.sv
// Purpose : FCP slave output-voltage controller: validates level requests and ramps out_volt one level per step.
// Latency : ack/nack one cycle after req_valid; first level change two cycles after an accepted request from IDLE.
// Backpr. : none; requests are never stalled. Requests during a ramp only retarget it.
//
// Ports:
//   clk, rstn           - single clock domain, asynchronous active-low reset
//   cap_mask            - runtime capability mask (bit 0 always treated as set)
//   req_valid/req_level - single-cycle request strobe and requested level code
//   req_ack/req_nack    - one-cycle accept / reject pulses
//   ping_from_master    - keep-alive pulse that clears the watchdog
//   reset_from_master   - forces level 0 on the next edge without ramping
//   out_volt            - current output level code (registered)
//   busy                - high while a step or settle is in progress
//   wdt_expired         - one-cycle pulse when the watchdog forces a fallback to level 0
module fcp_volt_ramp_ctrl #(
  parameter int VOLT_W     = 2,
  parameter int NUM_LEVELS = 3,
  parameter int STEP_CYC   = 1000,
  parameter int WDT_CYC    = 100000
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_LEVELS-1:0] cap_mask,
  input  logic                  req_valid,
  input  logic [VOLT_W-1:0]     req_level,
  output logic                  req_ack,
  output logic                  req_nack,
  input  logic                  ping_from_master,
  input  logic                  reset_from_master,
  output logic [VOLT_W-1:0]     out_volt,
  output logic                  busy,
  output logic                  wdt_expired
);

  // STEP_CYC of 1 would give a zero-width timer; keep at least one bit.
  localparam int TMR_W = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
  localparam int WDT_W = $clog2(WDT_CYC);

  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(STEP_CYC - 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STEP   = 2'd1,
    ST_SETTLE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [VOLT_W-1:0]  target_q, target_d;
  logic [VOLT_W-1:0]  out_volt_q, out_volt_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [WDT_W-1:0]   wdt_q, wdt_d;
  logic               req_ack_q, req_ack_d;
  logic               req_nack_q, req_nack_d;
  logic               busy_q, busy_d;
  logic               wdt_expired_q, wdt_expired_d;

  logic               level_ok;
  logic               req_accept;
  logic               wdt_active;
  logic               wdt_fire;

  // Request qualification: level must be in range and advertised in the mask.
  always_comb begin
    level_ok = 1'b0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (req_level == VOLT_W'(i) && (cap_mask[i] || i == 0)) begin
        level_ok = 1'b1;
      end
    end
  end

  assign req_accept = req_valid && level_ok && !reset_from_master;

  // Watchdog only runs while the output is, or is heading, above 5 V.
  assign wdt_active = (out_volt_q != '0) || (target_q != '0);

  // Expiry loses to master reset, an accepted request and a ping.
  assign wdt_fire = !reset_from_master && !req_accept && !ping_from_master &&
                    wdt_active && (wdt_q == WDT_LAST);

  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    out_volt_d    = out_volt_q;
    tmr_d         = tmr_q;
    wdt_d         = wdt_q;
    req_ack_d     = req_accept;
    req_nack_d    = req_valid && !req_accept;
    wdt_expired_d = wdt_fire;

    if (req_accept || ping_from_master || !wdt_active || wdt_fire) begin
      wdt_d = '0;
    end else begin
      wdt_d = wdt_q + WDT_W'(1);
    end

    if (req_accept) begin
      target_d = req_level;
    end else if (wdt_fire) begin
      target_d = '0;
    end

    case (state_q)
      ST_IDLE: begin
        // Covers both a new request and a watchdog retarget to 0.
        if (target_d != out_volt_q) begin
          state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        // Direction follows the target held before this edge; a request
        // landing in this same cycle only affects the next step.
        if (target_q > out_volt_q) begin
          out_volt_d = out_volt_q + VOLT_W'(1);
        end else if (target_q < out_volt_q) begin
          out_volt_d = out_volt_q - VOLT_W'(1);
        end
        tmr_d   = TMR_LOAD;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr_q == '0) begin
          // Compare against the incoming target so a retarget arriving in the
          // last settle cycle is never stranded in IDLE.
          state_d = (out_volt_q == target_d) ? ST_IDLE : ST_STEP;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (reset_from_master) begin
      state_d    = ST_IDLE;
      target_d   = '0;
      out_volt_d = '0;
      tmr_d      = '0;
      wdt_d      = '0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      out_volt_q    <= '0;
      tmr_q         <= '0;
      wdt_q         <= '0;
      req_ack_q     <= 1'b0;
      req_nack_q    <= 1'b0;
      busy_q        <= 1'b0;
      wdt_expired_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      out_volt_q    <= out_volt_d;
      tmr_q         <= tmr_d;
      wdt_q         <= wdt_d;
      req_ack_q     <= req_ack_d;
      req_nack_q    <= req_nack_d;
      busy_q        <= busy_d;
      wdt_expired_q <= wdt_expired_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign req_nack    = req_nack_q;
  assign out_volt    = out_volt_q;
  assign busy        = busy_q;
  assign wdt_expired = wdt_expired_q;

endmodule

// File: tb/tb_fcp_volt_ramp_ctrl.sv
// Bench for fcp_volt_ramp_ctrl: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic checked every cycle against a timeline model.
module tb_fcp_volt_ramp_ctrl;
  localparam int VW = 2;
  localparam int NL = 3;
  localparam int SC = 4;
  localparam int WC = 64;
  localparam logic [2:0] ALL = 3'b111;
  localparam logic [2:0] LO2 = 3'b011;

  logic          clk = 1'b0;
  logic          rstn;
  logic [NL-1:0] cap_mask;
  logic          req_valid;
  logic [VW-1:0] req_level;
  logic          req_ack, req_nack;
  logic          ping_from_master, reset_from_master;
  logic [VW-1:0] out_volt;
  logic          busy, wdt_expired;

  always #5 clk = ~clk;

  fcp_volt_ramp_ctrl #(.VOLT_W(VW), .NUM_LEVELS(NL), .STEP_CYC(SC), .WDT_CYC(WC)) dut (
    .clk(clk), .rstn(rstn), .cap_mask(cap_mask), .req_valid(req_valid), .req_level(req_level),
    .req_ack(req_ack), .req_nack(req_nack), .ping_from_master(ping_from_master),
    .reset_from_master(reset_from_master), .out_volt(out_volt), .busy(busy),
    .wdt_expired(wdt_expired)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: level/target plus the timestamp of the next step slot.
  int m_cyc, m_out, m_tgt, m_wdt, m_gate;
  bit m_ramp, m_ack, m_nack, m_exp;

  typedef struct {
    logic [2:0] cap;
    logic       rv;
    logic [1:0] rl;
    logic       mr;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [5:0] dut_vec();
    return {out_volt, busy, req_ack, req_nack, wdt_expired};
  endfunction

  function automatic logic [5:0] model_vec();
    logic [1:0] o;
    o = m_out[1:0];
    return {o, m_ramp, m_ack, m_nack, m_exp};
  endfunction

  task automatic chk_vec(input string name, input logic [5:0] got, input logic [5:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got out=%0d busy=%b ack=%b nack=%b wdt=%b, expected out=%0d busy=%b ack=%b nack=%b wdt=%b",
               name, cyc, got[5:4], got[3], got[2], got[1], got[0],
               exp[5:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cyc = 0; m_out = 0; m_tgt = 0; m_wdt = 0; m_gate = 0;
    m_ramp = 0; m_ack = 0; m_nack = 0; m_exp = 0;
  endtask

  // Advance the model by one cycle given this cycle's inputs.
  task automatic model_advance(input int rv, input int rl, input int pg, input int mr,
                               input logic [2:0] cap);
    bit ok, accept, active, fire;
    ok = 0;
    if (rl == 0) ok = 1;
    else if (rl < NL) ok = cap[rl];
    accept = (rv != 0) && ok && (mr == 0);
    active = (m_out != 0) || (m_tgt != 0);
    fire   = (mr == 0) && !accept && (pg == 0) && active && (m_wdt == WC - 1);
    m_ack  = accept;
    m_nack = (rv != 0) && !accept;
    m_exp  = fire;
    if (mr != 0 || accept || pg != 0 || !active || fire) m_wdt = 0;
    else m_wdt++;
    // A step slot moves the level toward the target as it stands in that slot.
    if (m_ramp && m_cyc == m_gate) begin
      if (m_tgt > m_out) m_out++;
      else if (m_tgt < m_out) m_out--;
      m_gate = m_cyc + 1 + SC;
    end
    if (accept) m_tgt = rl;
    else if (fire) m_tgt = 0;
    if (mr != 0) begin
      m_out = 0; m_tgt = 0; m_ramp = 0;
    end
    m_cyc++;
    if (m_ramp && m_cyc == m_gate && m_tgt == m_out) m_ramp = 0;
    else if (!m_ramp && m_tgt != m_out) begin
      m_ramp = 1;
      m_gate = m_cyc;
    end
  endtask

  // Drive one cycle of inputs, clock it, then compare every output with the model.
  task automatic tick(input logic rv, input logic [1:0] rl, input logic pg, input logic mr);
    req_valid = rv; req_level = rl; ping_from_master = pg; reset_from_master = mr;
    model_advance(int'(rv), int'(rl), int'(pg), int'(mr), cap_mask);
    @(posedge clk); #1;
    cyc++;
    req_valid = 1'b0; ping_from_master = 1'b0; reset_from_master = 1'b0;
    chk_vec("model", dut_vec(), model_vec());
  endtask

  task automatic idle();
    tick(1'b0, 2'd0, 1'b0, 1'b0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 200) begin
      idle();
      n++;
    end
    chk_int(name, int'(busy), 0);
  endtask

  task automatic go_level(input logic [1:0] lvl);
    tick(1'b1, lvl, 1'b0, 1'b0);
    wait_idle("go_level_idle");
    chk_int("go_level_out", int'(out_volt), int'(lvl));
  endtask

  task automatic add(input logic [2:0] cap, input logic rv, input logic [1:0] rl, input logic mr,
                     input logic [1:0] eo, input logic eb, input logic ea, input logic en);
    vec_t v;
    v.cap = cap; v.rv = rv; v.rl = rl; v.mr = mr;
    v.exp = {eo, eb, ea, en, 1'b0};
    tbl.push_back(v);
  endtask

  task automatic addn(input int n, input logic [2:0] cap, input logic [1:0] eo, input logic eb);
    for (int i = 0; i < n; i++) add(cap, 1'b0, 2'd0, 1'b0, eo, eb, 1'b0, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nz, pulses, first, j1, j0;
    rstn = 1'b0; cap_mask = ALL; req_valid = 1'b0; req_level = 2'd0;
    ping_from_master = 1'b0; reset_from_master = 1'b0;
    model_reset();

    // Reset state and quiet idle with periodic pings.
    repeat (3) @(posedge clk);
    #1;
    chk_vec("reset_hold", dut_vec(), 6'd0);
    rstn = 1'b1;
    chk_vec("reset_release", dut_vec(), 6'd0);
    nz = 0;
    for (int j = 0; j < 100; j++) begin
      tick(1'b0, 2'd0, ((j % 10) == 0), 1'b0);
      if (dut_vec() != 6'd0) nz++;
    end
    chk_int("reset_quiet", nz, 0);

    // Rows: cap, req_valid, req_level, reset_from_master | out, busy, ack, nack seen this cycle.
    // Ramp 0 -> 2.
    add(ALL, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    addn(5, ALL, 2'd1, 1'b1);
    addn(4, ALL, 2'd2, 1'b1);
    addn(2, ALL, 2'd2, 1'b0);
    // Ramp 2 -> 0.
    add(ALL, 1'b1, 2'd0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b0);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd2, 1'b1, 1'b1, 1'b0);
    addn(5, ALL, 2'd1, 1'b1);
    addn(4, ALL, 2'd0, 1'b1);
    addn(1, ALL, 2'd0, 1'b0);
    // Retarget to 0 in the fourth cycle of a ramp to 2.
    add(ALL, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    addn(2, ALL, 2'd1, 1'b1);
    add(ALL, 1'b1, 2'd0, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd1, 1'b1, 1'b1, 1'b0);
    addn(1, ALL, 2'd1, 1'b1);
    addn(4, ALL, 2'd0, 1'b1);
    addn(2, ALL, 2'd0, 1'b0);
    // Rejections: masked level, out-of-range level, request with master reset.
    add(LO2, 1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    add(LO2, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    add(ALL, 1'b1, 2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
    // Master reset in the middle of a ramp.
    add(LO2, 1'b1, 2'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    add(LO2, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 1'b0);
    add(LO2, 1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    // Request for the current level: ack without leaving idle.
    add(ALL, 1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
    add(ALL, 1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);

    foreach (tbl[i]) begin
      cap_mask = tbl[i].cap;
      chk_vec("table", dut_vec(), tbl[i].exp);
      tick(tbl[i].rv, tbl[i].rl, 1'b0, tbl[i].mr);
    end
    cap_mask = ALL;

    // Master reset from level 2 in idle: immediate drop, no watchdog pulse.
    go_level(2'd2);
    tick(1'b0, 2'd0, 1'b0, 1'b1);
    chk_vec("mreset_drop", dut_vec(), 6'd0);
    pulses = 0;
    for (int j = 0; j < 80; j++) begin
      idle();
      if (wdt_expired) pulses++;
    end
    chk_int("mreset_no_wdt", pulses, 0);

    // Watchdog: counter is 0 the cycle after the ping and reaches 63 at ping+64,
    // so the pulse is at ping+65 and the ramp down steps at +66 and +71.
    go_level(2'd2);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    pulses = 0; first = -1; j1 = -1; j0 = -1;
    for (int j = 1; j <= 90; j++) begin
      if (wdt_expired) begin
        pulses++;
        if (first < 0) first = j;
      end
      if (out_volt == 2'd1 && j1 < 0) j1 = j;
      if (out_volt == 2'd0 && j0 < 0) j0 = j;
      idle();
    end
    chk_int("wdt_pulse_count", pulses, 1);
    chk_int("wdt_pulse_cycle", first, WC + 1);
    chk_int("wdt_step1_cycle", j1, WC + 2);
    chk_int("wdt_step0_cycle", j0, WC + 2 + SC + 1);
    wait_idle("wdt_ramp_idle");

    // Ping landing in the expiry cycle suppresses it; next expiry is 64 cycles later.
    go_level(2'd2);
    tick(1'b0, 2'd0, 1'b1, 1'b0);
    pulses = 0; first = -1;
    for (int j = 1; j <= 140; j++) begin
      if (wdt_expired) begin
        pulses++;
        if (first < 0) first = j;
      end
      tick(1'b0, 2'd0, (j == WC), 1'b0);
    end
    chk_int("wdt_ping_suppress_count", pulses, 1);
    chk_int("wdt_ping_suppress_cycle", first, 2 * WC + 1);
    wait_idle("wdt_suppress_idle");

    // Randomized traffic in segments with differing request/ping/reset densities.
    for (int seg = 0; seg < 20; seg++) begin
      int rq, pp, mp, rsel;
      cap_mask = 3'($urandom_range(0, 7));
      rsel = $urandom_range(0, 2);
      rq = (rsel == 0) ? 25 : ((rsel == 1) ? 3 : 0);
      pp = ($urandom_range(0, 1) == 0) ? 15 : 0;
      mp = ($urandom_range(0, 1) == 0) ? 1 : 0;
      for (int j = 0; j < 150; j++) begin
        tick(($urandom_range(0, 99) < rq), 2'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < pp), ($urandom_range(0, 99) < mp));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
